// File: rtl/sam_enc_p.sv
// Pulse-width serial decoder: loads a frame length, XOR key and caps mask in CONFG,
// then decodes ones/zeros run-length symbols into MSG_W-bit frames in NORM.
module sam_enc_p #(
  parameter int MSG_W   = 8,
  parameter int CNT_W   = 6,
  parameter int MIN_RUN = 10,
  parameter int MAX_RUN = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             str,
  input  logic             mode,
  output logic [MSG_W-1:0] mesg,
  output logic [MSG_W-1:0] msgcd,
  output logic             mesg_vld,
  output logic             conf_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONFG = 2'd1,
    NORM  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_LEN  = 2'd0,
    PH_KEY  = 2'd1,
    PH_CAPS = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  localparam logic [3:0]       MSG_W4  = MSG_W[3:0];
  localparam logic [CNT_W:0]   MIN_S   = MIN_RUN[CNT_W:0];
  localparam logic [CNT_W:0]   MAX_S   = MAX_RUN[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [MSG_W-1:0] VEC_ONE = {{(MSG_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  phase_t             phase_r;
  logic [3:0]         cfg_cnt_r;
  logic [2:0]         len_sh_r;
  logic [3:0]         n_r;
  logic [MSG_W-1:0]   key_r;
  logic [MSG_W-1:0]   caps_r;
  logic [CNT_W-1:0]   ones_r;
  logic [CNT_W-1:0]   zeros_r;
  logic [3:0]         idx_r;
  logic [MSG_W-1:0]   shadow_r;

  logic               cfg_start_s;
  logic               cfg_load_s;
  logic               run_s;
  logic [CNT_W:0]     sum_s;
  logic               close_s;
  logic               accept_s;
  logic               bit_s;
  logic               last_s;
  logic [MSG_W-1:0]   frame_s;
  logic [3:0]         len_full_s;

  // Length field of 0 or beyond the message width means "use the full width".
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0 || len > MSG_W4) begin
      return MSG_W4;
    end else begin
      return len;
    end
  endfunction

  function automatic logic [MSG_W-1:0] set_bit(input logic [MSG_W-1:0] vec,
                                               input logic [3:0] pos,
                                               input logic b);
    return (vec & ~(VEC_ONE << pos)) | ({{(MSG_W-1){1'b0}}, b} << pos);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mode) state_nxt_s = CONFG;
        else      state_nxt_s = IDLE;
      end
      CONFG: begin
        if (mode)           state_nxt_s = CONFG;
        else if (conf_done) state_nxt_s = NORM;
        else                state_nxt_s = IDLE;
      end
      NORM: begin
        if (mode) state_nxt_s = IDLE;
        else      state_nxt_s = NORM;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    cfg_start_s = 1'b0;
    cfg_load_s  = 1'b0;
    run_s       = 1'b0;
    case (state_r)
      IDLE:    cfg_start_s = mode;
      CONFG:   cfg_load_s  = 1'b1;
      NORM:    run_s       = ~mode;
      default: run_s       = 1'b0;
    endcase
  end

  // Symbol classification from the current run counters.
  always_comb begin
    sum_s      = {1'b0, ones_r} + {1'b0, zeros_r};
    close_s    = run_s && str && (zeros_r != {CNT_W{1'b0}});
    accept_s   = close_s && (sum_s >= MIN_S) && (sum_s <= MAX_S);
    bit_s      = (ones_r >= zeros_r);
    last_s     = accept_s && (idx_r == 4'd0);
    frame_s    = set_bit(shadow_r, idx_r, bit_s);
    len_full_s = clamp_len({len_sh_r, str});
  end

  // Configuration loader: length, then key, then caps, all MSB-first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r   <= PH_LEN;
      cfg_cnt_r <= 4'd0;
      len_sh_r  <= 3'd0;
      n_r       <= 4'd0;
      key_r     <= {MSG_W{1'b0}};
      caps_r    <= {MSG_W{1'b0}};
      conf_done <= 1'b0;
    end else if (cfg_start_s) begin
      phase_r   <= PH_LEN;
      cfg_cnt_r <= 4'd0;
      len_sh_r  <= 3'd0;
      n_r       <= 4'd0;
      key_r     <= {MSG_W{1'b0}};
      caps_r    <= {MSG_W{1'b0}};
      conf_done <= 1'b0;
    end else if (cfg_load_s) begin
      case (phase_r)
        PH_LEN: begin
          len_sh_r <= {len_sh_r[1:0], str};
          if (cfg_cnt_r == 4'd3) begin
            n_r       <= len_full_s;
            cfg_cnt_r <= len_full_s - 4'd1;
            phase_r   <= PH_KEY;
          end else begin
            cfg_cnt_r <= cfg_cnt_r + 4'd1;
          end
        end
        PH_KEY: begin
          key_r <= set_bit(key_r, cfg_cnt_r, str);
          if (cfg_cnt_r == 4'd0) begin
            cfg_cnt_r <= n_r - 4'd1;
            phase_r   <= PH_CAPS;
          end else begin
            cfg_cnt_r <= cfg_cnt_r - 4'd1;
          end
        end
        PH_CAPS: begin
          caps_r <= set_bit(caps_r, cfg_cnt_r, str);
          if (cfg_cnt_r == 4'd0) begin
            phase_r   <= PH_DONE;
            conf_done <= 1'b1;
          end else begin
            cfg_cnt_r <= cfg_cnt_r - 4'd1;
          end
        end
        PH_DONE: phase_r <= PH_DONE;
        default: phase_r <= PH_DONE;
      endcase
    end
  end

  // Saturating run counters; a leading 0 with no preceding 1 is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_r  <= {CNT_W{1'b0}};
      zeros_r <= {CNT_W{1'b0}};
    end else if (!run_s) begin
      ones_r  <= {CNT_W{1'b0}};
      zeros_r <= {CNT_W{1'b0}};
    end else if (str) begin
      if (zeros_r != {CNT_W{1'b0}}) begin
        ones_r  <= CNT_ONE;
        zeros_r <= {CNT_W{1'b0}};
      end else if (ones_r != CNT_MAX) begin
        ones_r <= ones_r + CNT_ONE;
      end
    end else if (ones_r != {CNT_W{1'b0}} && zeros_r != CNT_MAX) begin
      zeros_r <= zeros_r + CNT_ONE;
    end
  end

  // Frame assembly and output update on the bit-0 symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_r <= {MSG_W{1'b0}};
      idx_r    <= 4'd0;
      mesg     <= {MSG_W{1'b0}};
      msgcd    <= {MSG_W{1'b0}};
    end else if (!run_s) begin
      shadow_r <= {MSG_W{1'b0}};
      idx_r    <= n_r - 4'd1;
    end else if (accept_s) begin
      if (last_s) begin
        shadow_r <= {MSG_W{1'b0}};
        idx_r    <= n_r - 4'd1;
        mesg     <= frame_s;
        msgcd    <= (frame_s ^ key_r) | caps_r;
      end else begin
        shadow_r <= frame_s;
        idx_r    <= idx_r - 4'd1;
      end
    end
  end

  // One-cycle valid pulse accompanying each output update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mesg_vld <= 1'b0;
    end else begin
      mesg_vld <= last_s;
    end
  end

endmodule

// File: tb/tb_sam_enc_p.sv
// Scoreboard bench for sam_enc_p: directed configurations and pulse-width frames,
// expected {mesg,msgcd} pairs queued at issue time and checked by a monitor.
module tb_sam_enc_p;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       str = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] mesg;
  logic [7:0] msgcd;
  logic       mesg_vld;
  logic       conf_done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  sam_enc_p #(.MSG_W(8), .CNT_W(6), .MIN_RUN(10), .MAX_RUN(60)) dut (
    .clk(clk), .reset(reset), .str(str), .mode(mode),
    .mesg(mesg), .msgcd(msgcd), .mesg_vld(mesg_vld), .conf_done(conf_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse pops one expected frame.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mesg_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_vld: got mesg=%0h msgcd=%0h expected no pulse at %0t",
                 mesg, msgcd, $time);
      end else begin
        e = exp_q.pop_front();
        check("mesg", {24'd0, mesg}, {24'd0, e[15:8]});
        check("msgcd", {24'd0, msgcd}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sym(input int o, input int z);
    str = 1'b1; tick(o);
    str = 1'b0; tick(z);
  endtask

  task automatic bitsym(input logic b);
    if (b) sym(8, 4);
    else   sym(4, 8);
  endtask

  task automatic close_sym();
    str = 1'b1; tick(1);
    str = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bitsym(bits[i]);
  endtask

  task automatic go_idle();
    mode = 1'b1; str = 1'b0; tick(1);
    mode = 1'b0; tick(1);
  endtask

  task automatic cfg(input logic [35:0] v, input int nb);
    go_idle();
    mode = 1'b1; tick(1);
    for (int i = 0; i < nb; i++) begin
      str = v[nb-1-i];
      if (i == nb - 1) check("conf_done_before_last", {31'd0, conf_done}, 32'd0);
      tick(1);
    end
    check("conf_done_after_last", {31'd0, conf_done}, 32'd1);
    mode = 1'b0; str = 1'b0; tick(1);
  endtask

  initial begin
    tick(2);
    check("rst_mesg", {24'd0, mesg}, 32'd0);
    check("rst_msgcd", {24'd0, msgcd}, 32'd0);
    check("rst_vld", {31'd0, mesg_vld}, 32'd0);
    check("rst_conf_done", {31'd0, conf_done}, 32'd0);
    reset = 1'b1;
    tick(1);

    // N=4, key 1010, caps 0001
    cfg({24'd0, 4'b0100, 4'b1010, 4'b0001}, 12);

    // Boundary sums: 10 and 60 accepted, 9 and 61 rejected -> 1101
    exp_q.push_back({8'h0D, 8'h07});
    sym(5, 5); sym(30, 30); sym(4, 5); sym(31, 30); sym(2, 8); sym(5, 5);
    close_sym();

    // Reference frame 1011
    exp_q.push_back({8'h0B, 8'h01});
    send_frame(8'b0000_1011, 4);
    close_sym();

    // Rejected 3/3 and 40/30 mid-frame, then a continuous second frame 0110
    exp_q.push_back({8'h0B, 8'h01});
    exp_q.push_back({8'h06, 8'h0D});
    bitsym(1'b1); sym(3, 3); sym(40, 30); bitsym(1'b0); bitsym(1'b1); bitsym(1'b1);
    send_frame(8'b0000_0110, 4);
    close_sym();

    // 100 ones saturate the counter; symbol rejected mid-frame -> 0110
    exp_q.push_back({8'h06, 8'h0D});
    bitsym(1'b0); sym(100, 5); bitsym(1'b1); bitsym(1'b1); bitsym(1'b0);
    close_sym();

    // Reset during a partial frame clears outputs at once
    bitsym(1'b1); bitsym(1'b0);
    str = 1'b1; tick(3);
    check("mesg_before_reset", {24'd0, mesg}, 32'h06);
    #2 reset = 1'b0;
    #1;
    check("async_rst_mesg", {24'd0, mesg}, 32'd0);
    check("async_rst_msgcd", {24'd0, msgcd}, 32'd0);
    check("async_rst_conf_done", {31'd0, conf_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1; str = 1'b0; mode = 1'b0;
    send_frame(8'b0000_1011, 4);
    close_sym();
    tick(2);
    check("no_run_without_cfg", {24'd0, mesg}, 32'd0);

    // Length 0000 -> 8-bit frame, key 5A, caps 81
    cfg({16'd0, 4'b0000, 8'h5A, 8'h81}, 20);
    exp_q.push_back({8'hCA, 8'h91});
    send_frame(8'hCA, 8);
    close_sym();

    // Length 12 clamps to 8, key FF, caps 00
    cfg({16'd0, 4'b1100, 8'hFF, 8'h00}, 20);
    exp_q.push_back({8'h3C, 8'hC3});
    send_frame(8'h3C, 8);
    close_sym();
    tick(2);

    // Abort config after 6 bits: back to IDLE, run never starts
    go_idle();
    mode = 1'b1; tick(1);
    for (int i = 0; i < 6; i++) begin
      str = i[0]; tick(1);
    end
    mode = 1'b0; str = 1'b0; tick(1);
    check("aborted_conf_done", {31'd0, conf_done}, 32'd0);
    send_frame(8'b0000_1011, 4);
    close_sym();
    tick(2);
    check("mesg_holds", {24'd0, mesg}, 32'h3C);

    tick(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sam_enc_p.md
SAM_ENC_P -- requirements
Module: sam_enc_p

Interface
REQ-001 SHALL provide parameter: MSG_W, 8, maximum message length in bits (1..15).
REQ-002 SHALL provide parameter: CNT_W, 6, width of run-length counters.
REQ-003 SHALL provide parameter: MIN_RUN, 10, minimum accepted symbol length (ones+zeros) in clocks.
REQ-004 SHALL provide parameter: MAX_RUN, 60, maximum accepted symbol length in clocks.
REQ-005 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port: str  input  1  serial stream: config bits in CONFG, pulse-width symbols in NORM.
REQ-008 SHALL provide port: mode  input  1  1 = configure request, 0 = run.
REQ-009 SHALL provide port: mesg  output  MSG_W  last complete decoded frame, raw.
REQ-010 SHALL provide port: msgcd  output  MSG_W  last complete frame coded: (mesg XOR key) OR caps, bitwise.
REQ-011 SHALL provide port: mesg_vld  output  1  one-cycle pulse when mesg/msgcd update.
REQ-012 SHALL provide port: conf_done  output  1  high once a full configuration has been loaded.

Function
REQ-013 SHALL implement FSM states IDLE, CONFG, NORM; IDLE->CONFG when mode=1; CONFG->NORM when mode=0 and conf_done=1; CONFG->IDLE when mode=0 and conf_done=0; NORM->IDLE when mode=1; otherwise hold.
REQ-014 SHALL, on IDLE->CONFG, clear conf_done, key, caps and config counters, and restart loading on the next cycle.
REQ-015 SHALL, in CONFG, shift 4 bits of str MSB-first into frame length N; N=0 or N>MSG_W SHALL be clamped to MSG_W.
REQ-016 SHALL then load N key bits MSB-first into key[N-1:0], then N caps bits MSB-first into caps[N-1:0]; bits above N-1 SHALL be 0.
REQ-017 SHALL set conf_done on the edge sampling the last caps bit and ignore further str in CONFG.
REQ-018 SHALL, in NORM, count consecutive 1s (ones) then following 0s (zeros); 0s before the first 1 of a symbol SHALL be ignored.
REQ-019 SHALL close a symbol on the edge where str=1 is sampled with zeros>0; that 1 SHALL start the next symbol (ones=1, zeros=0).
REQ-020 SHALL accept a closed symbol only if MIN_RUN <= ones+zeros <= MAX_RUN, sum computed in CNT_W+1 bits; decoded bit = (ones >= zeros).
REQ-021 SHALL discard rejected symbols without changing bit index or outputs.
REQ-022 SHALL saturate ones and zeros at 2^CNT_W-1 (no wrap).
REQ-023 SHALL store accepted bits MSB-first at index N-1 down to 0 in a shadow register.
REQ-024 SHALL, on the edge accepting bit 0, load mesg from shadow including that bit, load msgcd, pulse mesg_vld for exactly one cycle, and reload index to N-1 for continuous frames.
REQ-025 SHALL, on NORM->IDLE, discard partial frame and run counters; mesg/msgcd SHALL hold.
REQ-026 SHALL keep mesg_vld low outside NORM.

Reset
REQ-027 SHALL on reset=0 force state IDLE, mesg=0, msgcd=0, mesg_vld=0, conf_done=0, key=0, caps=0, N=0, counters=0, immediately and independent of clk.
REQ-028 SHALL, on reset mid-frame or mid-config, lose all partial state; a full reconfiguration SHALL be required before NORM.

Verification
REQ-029 Config N=4 (0100), key 1010, caps 0001, mode->0; symbols 8x1/4x0, 4x1/8x0, 8x1/4x0, 8x1/4x0 then a 1 -> mesg=0x0B, msgcd=0x01|(0x0B^0x0A)=0x01, one mesg_vld pulse.
REQ-030 Symbol 3x1/3x0 (sum 6) and 40x1/30x0 (sum 70) -> both rejected, no index change, no mesg_vld.
REQ-031 Length field 0000 with MSG_W=8 -> 8 key and 8 caps bits loaded, conf_done after 20 config cycles.
REQ-032 mode dropped after 6 config bits -> IDLE, conf_done=0, NORM never entered.
REQ-033 100 consecutive 1s then 0s -> ones saturates at 63, symbol rejected (sum>60).
REQ-034 reset asserted between bits 2 and 3 of a frame -> outputs 0 immediately; post-reset NORM requires reconfig.
